// File: rtl/blur_pkg.sv
// Shared types and constants for the horizontal box-blur filter.
package blur_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_RGB    = 2'd1,
      MODE_GREY   = 2'd2
   } mode_e;

   localparam logic [3:0] ADDR_MODE   = 4'd0;
   localparam logic [3:0] ADDR_TAPS   = 4'd1;
   localparam logic [3:0] ADDR_FRAMES = 4'd2;
   localparam logic [3:0] ADDR_ACTIVE = 4'd3;

   // TAPS is a power of two, so this is an exact log2.
   function automatic int log2_taps(input int taps);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << i) < taps) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/box_blur_rgb_window.sv
// One channel's trailing window: TAPS-deep shift register plus running sum.
// avg_o is combinational from the incoming pixel; state advances only when en_i is set.
module blur_window
   import blur_pkg::*;
#(
   parameter int CH_W = 8,
   parameter int TAPS = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en_i,
   input  logic            clamp_i,
   input  logic [CH_W-1:0] pix_i,
   output logic [CH_W-1:0] avg_o
);

   localparam int LG = log2_taps(TAPS);
   localparam int SW = CH_W + LG;

   logic [TAPS-1:0][CH_W-1:0] taps_q, taps_d;
   logic [SW-1:0]             sum_q, sum_d;

   always_comb begin
      taps_d = taps_q;
      sum_d  = sum_q;
      if (clamp_i) begin
         // Line start: pretend the first pixel extends left of the edge.
         for (int i = 0; i < TAPS; i++) taps_d[i] = pix_i;
         sum_d = SW'(pix_i) << LG;
      end else begin
         taps_d[0] = pix_i;
         for (int i = 1; i < TAPS; i++) taps_d[i] = taps_q[i-1];
         sum_d = sum_q + SW'(pix_i) - SW'(taps_q[TAPS-1]);
      end
   end

   assign avg_o = CH_W'(sum_d >> LG);

   always_ff @(posedge clk) begin
      if (reset) begin
         taps_q <= '0;
         sum_q  <= '0;
      end else if (en_i) begin
         taps_q <= taps_d;
         sum_q  <= sum_d;
      end
   end

endmodule

// File: rtl/box_blur_rgb.sv
// Avalon-ST horizontal box blur with MM-controlled mode; one-cycle registered output stage.
// Backpressure: sink_ready follows the output register (free or being drained this cycle).
module box_blur_rgb
   import blur_pkg::*;
#(
   parameter int TAPS     = 4,
   parameter int CH_W     = 8,
   parameter int CHANNELS = 3,
   parameter int IMAGE_W  = 640
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [CHANNELS*CH_W-1:0] sink_data,
   input  logic                     sink_valid,
   input  logic                     sink_sop,
   input  logic                     sink_eop,
   output logic                     sink_ready,
   output logic [CHANNELS*CH_W-1:0] source_data,
   output logic                     source_valid,
   output logic                     source_sop,
   output logic                     source_eop,
   input  logic                     source_ready,
   input  logic                     s_chipselect,
   input  logic                     s_read,
   input  logic                     s_write,
   input  logic [3:0]               s_address,
   input  logic [31:0]              s_writedata,
   output logic [31:0]              s_readdata
);

   localparam int DW = CHANNELS * CH_W;
   localparam int CW = $clog2(IMAGE_W + 1);

   logic          src_valid_q, src_sop_q, src_eop_q;
   logic [DW-1:0] src_data_q, src_data_d;
   logic          is_video_q, is_video_d;
   logic [CW-1:0] col_q, col_d;
   logic [1:0]    mode_q, mode_d, active_mode_q, active_mode_d;
   logic [15:0]   frames_q, frames_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          acc, sop_video, vid_beat;
   logic [CHANNELS-1:0][CH_W-1:0] avg;
   logic          unused_wdata;

   assign sink_ready   = ~reset && (~src_valid_q || source_ready);
   assign acc          = sink_valid && sink_ready;
   assign sop_video    = (sink_data[3:0] == 4'd0);
   assign vid_beat     = acc && ~sink_sop && is_video_q;
   assign unused_wdata = ^{s_writedata[31:2], 1'b0};

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      blur_window #(.CH_W(CH_W), .TAPS(TAPS)) u_win (
         .clk     (clk),
         .reset   (reset),
         .en_i    (vid_beat),
         .clamp_i (col_q == '0),
         .pix_i   (sink_data[c*CH_W +: CH_W]),
         .avg_o   (avg[c])
      );
   end

   always_comb begin
      is_video_d    = is_video_q;
      col_d         = col_q;
      mode_d        = mode_q;
      active_mode_d = active_mode_q;
      frames_d      = frames_q;
      rdata_d       = rdata_q;
      src_data_d    = sink_data;

      if (acc && sink_sop) begin
         is_video_d    = sop_video;
         col_d         = '0;
         active_mode_d = mode_q;
      end else if (vid_beat) begin
         col_d = (col_q == CW'(IMAGE_W - 1)) ? '0 : col_q + CW'(1);
         if (active_mode_q == MODE_RGB)       src_data_d = avg;
         else if (active_mode_q == MODE_GREY) src_data_d = {CHANNELS{avg[0]}};
      end

      if (acc && sink_eop && (sink_sop ? sop_video : is_video_q)) frames_d = frames_q + 16'd1;

      // A read in the same cycle wins; the write is dropped.
      if (s_chipselect && s_read) begin
         case (s_address)
            ADDR_MODE:   rdata_d = {30'd0, mode_q};
            ADDR_TAPS:   rdata_d = 32'(TAPS);
            ADDR_FRAMES: rdata_d = {16'd0, frames_q};
            ADDR_ACTIVE: rdata_d = {30'd0, active_mode_q};
            default:     rdata_d = '0;
         endcase
      end else if (s_chipselect && s_write && (s_address == ADDR_MODE)) begin
         mode_d = s_writedata[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         src_valid_q   <= 1'b0;
         src_sop_q     <= 1'b0;
         src_eop_q     <= 1'b0;
         src_data_q    <= '0;
         is_video_q    <= 1'b0;
         col_q         <= '0;
         mode_q        <= MODE_RGB;
         active_mode_q <= MODE_RGB;
         frames_q      <= '0;
         rdata_q       <= '0;
      end else begin
         is_video_q    <= is_video_d;
         col_q         <= col_d;
         mode_q        <= mode_d;
         active_mode_q <= active_mode_d;
         frames_q      <= frames_d;
         rdata_q       <= rdata_d;
         if (sink_ready) begin
            src_valid_q <= sink_valid;
            if (acc) begin
               src_data_q <= src_data_d;
               src_sop_q  <= sink_sop;
               src_eop_q  <= sink_eop;
            end
         end
      end
   end

   assign source_valid = src_valid_q;
   assign source_sop   = src_sop_q;
   assign source_eop   = src_eop_q;
   assign source_data  = src_data_q;
   assign s_readdata   = rdata_q;

endmodule

// File: tb/tb_box_blur_rgb.sv
// Directed bench for box_blur_rgb: TAPS=4, 8-bit RGB, 4-pixel lines, scoreboarded output stream.
`timescale 1ns/1ps
module tb_box_blur_rgb;

   localparam int DW = 24;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] sink_data;
   logic          sink_valid, sink_sop, sink_eop, sink_ready;
   logic [DW-1:0] source_data;
   logic          source_valid, source_sop, source_eop, source_ready;
   logic          s_chipselect, s_read, s_write;
   logic [3:0]    s_address;
   logic [31:0]   s_writedata, s_readdata;

   always #5 clk = ~clk;

   box_blur_rgb #(.TAPS(4), .CH_W(8), .CHANNELS(3), .IMAGE_W(4)) dut (
      .clk(clk), .reset(reset),
      .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop),
      .sink_eop(sink_eop), .sink_ready(sink_ready),
      .source_data(source_data), .source_valid(source_valid), .source_sop(source_sop),
      .source_eop(source_eop), .source_ready(source_ready),
      .s_chipselect(s_chipselect), .s_read(s_read), .s_write(s_write),
      .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata)
   );

   typedef struct packed {logic sop; logic eop; logic [DW-1:0] dat;} beat_t;
   typedef struct packed {logic sop; logic eop; logic [DW-1:0] din; logic [DW-1:0] dout;} vec_t;

   int     checks = 0;
   int     errors = 0;
   beat_t  exp_q[$];
   beat_t  e;
   vec_t   tbl [17];
   logic   rnd_en = 1'b0;
   logic   hold_vld = 1'b0;
   logic [DW+1:0] hold_val;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Scoreboard: every handshaked output beat must match the next expected beat.
   always @(negedge clk) begin
      if (!reset && source_valid && source_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%h required=none", source_data);
         end else begin
            e = exp_q.pop_front();
            check("out_beat", {6'd0, source_sop, source_eop, source_data}, {6'd0, e.sop, e.eop, e.dat});
         end
      end
      if (hold_vld && source_valid && !reset)
         check("hold_stable", {6'd0, source_sop, source_eop, source_data}, {6'd0, hold_val});
      hold_vld = source_valid && !source_ready && !reset;
      hold_val = {source_sop, source_eop, source_data};
   end

   always @(posedge clk) begin
      if (rnd_en) begin
         #1;
         source_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic send(input logic s, input logic eo, input logic [DW-1:0] d);
      int n;
      n = 0;
      sink_valid = 1'b1; sink_sop = s; sink_eop = eo; sink_data = d;
      @(negedge clk);
      while (!sink_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!sink_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=not_ready required=ready");
      end
      @(posedge clk); #1;
      sink_valid = 1'b0;
   endtask

   task automatic mm_read(input logic [3:0] a, output logic [31:0] d);
      s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
      @(posedge clk); #1;
      s_chipselect = 1'b0; s_read = 1'b0;
      d = s_readdata;
   endtask

   task automatic mm_write(input logic [3:0] a, input logic [31:0] w);
      s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = w;
      @(posedge clk); #1;
      s_chipselect = 1'b0; s_write = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] req);
      logic [31:0] d;
      mm_read(a, d);
      check(name, d, req);
   endtask

   task automatic push(input logic s, input logic eo, input logic [DW-1:0] d);
      exp_q.push_back('{s, eo, d});
   endtask

   task automatic apply_tbl(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         push(tbl[i].sop, tbl[i].eop, tbl[i].dout);
         send(tbl[i].sop, tbl[i].eop, tbl[i].din);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk); #1;
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      // Frame A: RGB ramp line, then a line with distinct per-channel values.
      tbl[0]  = '{1'b1, 1'b0, 24'h000000, 24'h000000};
      tbl[1]  = '{1'b0, 1'b0, 24'h040404, 24'h040404};
      tbl[2]  = '{1'b0, 1'b0, 24'h080808, 24'h050505};
      tbl[3]  = '{1'b0, 1'b0, 24'h0C0C0C, 24'h070707};
      tbl[4]  = '{1'b0, 1'b0, 24'h101010, 24'h0A0A0A};
      tbl[5]  = '{1'b0, 1'b0, 24'h000AC8, 24'h000AC8};
      tbl[6]  = '{1'b0, 1'b0, 24'hFF1E64, 24'h3F0FAF};
      tbl[7]  = '{1'b0, 1'b0, 24'hFF3200, 24'h7F197D};
      tbl[8]  = '{1'b0, 1'b1, 24'hFF4628, 24'hBF2855};
      // Control packet: bit-exact passthrough.
      tbl[9]  = '{1'b1, 1'b0, 24'h00000F, 24'h00000F};
      tbl[10] = '{1'b0, 1'b0, 24'h123456, 24'h123456};
      tbl[11] = '{1'b0, 1'b1, 24'hABCDEF, 24'hABCDEF};
      // Frame B: full-scale pixels stay at full scale.
      tbl[12] = '{1'b1, 1'b0, 24'h000000, 24'h000000};
      tbl[13] = '{1'b0, 1'b0, 24'hFFFFFF, 24'hFFFFFF};
      tbl[14] = '{1'b0, 1'b0, 24'hFFFFFF, 24'hFFFFFF};
      tbl[15] = '{1'b0, 1'b0, 24'hFFFFFF, 24'hFFFFFF};
      tbl[16] = '{1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF};

      reset = 1'b1; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_data = '0;
      source_ready = 1'b1; s_chipselect = 1'b0; s_read = 1'b0; s_write = 1'b0;
      s_address = '0; s_writedata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", {6'd0, source_valid, source_sop, source_eop, sink_ready, source_data[21:0]},
            32'd0);
      check("rst_data", {8'd0, source_data}, 32'd0);
      check("rst_readdata", s_readdata, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      read_check("mode_rst", 4'd0, 32'd1);
      read_check("taps", 4'd1, 32'd4);
      read_check("frames_rst", 4'd2, 32'd0);
      read_check("active_rst", 4'd3, 32'd1);
      read_check("unmapped", 4'd9, 32'd0);

      apply_tbl(0, 16);
      drain();
      read_check("frames_after_tbl", 4'd2, 32'd2);

      // Mode written mid-frame only takes effect at the next sop.
      push(1'b1, 1'b0, 24'h0); send(1'b1, 1'b0, 24'h0);
      mm_write(4'd0, 32'd0);
      read_check("active_mid", 4'd3, 32'd1);
      read_check("mode_shadow", 4'd0, 32'd0);
      for (int j = 1; j <= 4; j++) begin
         push(1'b0, j == 4, tbl[j].dout);
         send(1'b0, j == 4, tbl[j].din);
      end
      push(1'b1, 1'b0, 24'h0); send(1'b1, 1'b0, 24'h0);
      read_check("active_next", 4'd3, 32'd0);
      for (int j = 1; j <= 4; j++) begin
         push(1'b0, j == 4, tbl[j].din);
         send(1'b0, j == 4, tbl[j].din);
      end
      drain();
      read_check("frames_mode", 4'd2, 32'd4);

      // Two RGB frames under random backpressure.
      mm_write(4'd0, 32'd1);
      rnd_en = 1'b1;
      apply_tbl(0, 8);
      apply_tbl(0, 8);
      drain();
      rnd_en = 1'b0;
      @(posedge clk); #2;
      source_ready = 1'b1;
      read_check("frames_rnd", 4'd2, 32'd6);

      // Read and write together: the write is dropped; RO writes ignored.
      s_chipselect = 1'b1; s_read = 1'b1; s_write = 1'b1; s_address = 4'd0; s_writedata = 32'd3;
      @(posedge clk); #1;
      s_chipselect = 1'b0; s_read = 1'b0; s_write = 1'b0;
      check("rw_read", s_readdata, 32'd1);
      read_check("rw_mode", 4'd0, 32'd1);
      mm_write(4'd2, 32'h55);
      read_check("ro_write", 4'd2, 32'd6);

      // Write landing on the same edge as a sop: that sop keeps the old mode.
      push(1'b1, 1'b0, 24'h0);
      fork
         send(1'b1, 1'b0, 24'h0);
         mm_write(4'd0, 32'd2);
      join
      read_check("sop_old_mode", 4'd3, 32'd1);
      read_check("sop_new_shadow", 4'd0, 32'd2);
      push(1'b0, 1'b1, 24'h0000FF); send(1'b0, 1'b1, 24'h0000FF);

      // GREY: red-only pixel replicates to all channels.
      push(1'b1, 1'b0, 24'h0); send(1'b1, 1'b0, 24'h0);
      read_check("active_grey", 4'd3, 32'd2);
      for (int j = 0; j < 3; j++) begin
         push(1'b0, 1'b0, 24'hFFFFFF);
         send(1'b0, 1'b0, 24'h0000FF);
      end
      drain();

      // Hold a beat under backpressure, then reset mid-line.
      source_ready = 1'b0;
      send(1'b0, 1'b0, 24'h0000FF);
      check("held_valid", {31'd0, source_valid}, 32'd1);
      check("held_data", {8'd0, source_data}, 32'h00FFFFFF);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("reset_flush", {29'd0, source_valid, sink_ready, source_sop}, 32'd0);
      check("reset_data", {8'd0, source_data}, 32'd0);
      reset = 1'b0;
      source_ready = 1'b1;
      read_check("mode_after_rst", 4'd0, 32'd1);
      read_check("active_after_rst", 4'd3, 32'd1);

      // Tail of the interrupted packet is treated as control.
      push(1'b0, 1'b0, 24'h000004); send(1'b0, 1'b0, 24'h000004);
      push(1'b0, 1'b1, 24'h000010); send(1'b0, 1'b1, 24'h000010);
      drain();
      read_check("frames_tail", 4'd2, 32'd0);

      // A second sop without eop restarts the line.
      push(1'b1, 1'b0, 24'h0);      send(1'b1, 1'b0, 24'h0);
      push(1'b0, 1'b0, 24'h080808); send(1'b0, 1'b0, 24'h080808);
      push(1'b0, 1'b0, 24'h0A0A0A); send(1'b0, 1'b0, 24'h101010);
      push(1'b1, 1'b0, 24'h0);      send(1'b1, 1'b0, 24'h0);
      push(1'b0, 1'b0, 24'h404040); send(1'b0, 1'b0, 24'h404040);
      push(1'b0, 1'b1, 24'h383838); send(1'b0, 1'b1, 24'h202020);
      drain();
      read_check("frames_resop", 4'd2, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
